cnn_image_feeder: RTL and testbench

// - Upstream stage of cnn_core_top.
// - Collects one 28x28 u8 image from a byte stream (UART/host side) into local RAM.
// - Replays the image to the core as exactly 784 back-to-back data_valid cycles.
// - Waits for the core's out_valid, latches the 4-bit decision, then re-arms for the next image.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/cnn_img_ram.sv | 37 +++
 rtl/cnn_image_feeder.sv | 176 +++++++++++++++++
 tb/tb_cnn_image_feeder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and FSM encoding for the CNN image feeder.
package cnn_pkg;

  localparam int unsigned IMG_W       = 28;
  localparam int unsigned IMG_H       = 28;
  localparam int unsigned N_PIX       = IMG_W * IMG_H;
  localparam int unsigned PIX_W       = 8;
  localparam int unsigned DATA_W      = PIX_W;
  localparam int unsigned CLS_W       = 4;
  localparam int unsigned TIMEOUT_CYC = 8192;
  localparam int unsigned ADDR_W      = $clog2(N_PIX);
  localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

endpackage

// File: rtl/cnn_img_ram.sv
// Simple dual-port image buffer: one write port, one synchronous read port.
module cnn_img_ram
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH = N_PIX,
  parameter int unsigned WIDTH = DATA_W,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port; contents are intentionally not reset so this maps to block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port with one cycle of latency.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cnn_image_feeder.sv
// Buffers one 28x28 image from a byte stream, replays it to the CNN core
// as a gapless burst, then waits for (or times out on) the core's decision.
module cnn_image_feeder
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] core_data_in,
  output logic              core_data_valid,
  input  logic [CLS_W-1:0]  core_decision,
  input  logic              core_out_valid,
  output logic [CLS_W-1:0]  result,
  output logic              result_valid,
  output logic              err_timeout,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ADDR_W-1:0]   r_pix_cnt;
  logic [ADDR_W-1:0]   r_rd_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;
  logic                r_rd_vld;

  logic                r_s_ready;
  logic [DATA_W-1:0]   r_core_data_in;
  logic                r_core_data_valid;
  logic [CLS_W-1:0]    r_result;
  logic                r_result_valid;
  logic                r_err_timeout;
  logic                r_busy;

  logic                w_beat;
  logic                w_pix_last;
  logic                w_rd_last;
  logic                w_tmo_last;
  logic                w_rd_en;
  logic [DATA_W-1:0]   w_ram_dout;

  logic                w_s_ready_nxt;
  logic                w_busy_nxt;
  logic [CLS_W-1:0]    w_result_nxt;
  logic                w_result_valid_nxt;
  logic                w_err_timeout_nxt;

  assign w_beat     = s_valid & r_s_ready & (r_state == ST_LOAD);
  assign w_pix_last = (r_pix_cnt == ADDR_W'(N_PIX - 1));
  assign w_rd_last  = (r_rd_cnt  == ADDR_W'(N_PIX - 1));
  assign w_tmo_last = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign w_rd_en    = (r_state == ST_STREAM);

  cnn_img_ram #(
    .DEPTH (N_PIX),
    .WIDTH (DATA_W),
    .AW    (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_beat),
    .i_wr_addr (r_pix_cnt),
    .i_wr_data (s_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_cnt),
    .o_rd_data (w_ram_dout)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; a core answer takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:   if (w_beat && w_pix_last)          w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_rd_last)                     w_state_nxt = ST_WAIT;
      ST_WAIT:   if (core_out_valid || w_tmo_last)  w_state_nxt = ST_LOAD;
      default:                                      w_state_nxt = ST_LOAD;
    endcase
  end

  // FSM output logic: next values for the registered status outputs.
  always_comb begin
    w_s_ready_nxt      = (w_state_nxt == ST_LOAD);
    w_busy_nxt         = (w_state_nxt == ST_STREAM) || (w_state_nxt == ST_WAIT);
    w_result_nxt       = r_result;
    w_result_valid_nxt = 1'b0;
    w_err_timeout_nxt  = 1'b0;
    if (r_state == ST_WAIT) begin
      if (core_out_valid) begin
        w_result_nxt       = core_decision;
        w_result_valid_nxt = 1'b1;
      end else if (w_tmo_last) begin
        w_err_timeout_nxt  = 1'b1;
      end
    end
  end

  // Status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ready      <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_s_ready      <= w_s_ready_nxt;
      r_busy         <= w_busy_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_err_timeout  <= w_err_timeout_nxt;
    end
  end

  // Write pointer: wraps only on the terminal-count compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt <= '0;
    end else if (w_beat) begin
      r_pix_cnt <= w_pix_last ? '0 : r_pix_cnt + 1'b1;
    end
  end

  // Read pointer: one address per STREAM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
    end else if (r_state == ST_STREAM) begin
      r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
    end else begin
      r_rd_cnt <= '0;
    end
  end

  // Timeout counter: runs only while waiting, cleared on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  // Pixel pipeline: RAM read stage, then registered core interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld          <= 1'b0;
      r_core_data_valid <= 1'b0;
      r_core_data_in    <= '0;
    end else begin
      r_rd_vld          <= (r_state == ST_STREAM);
      r_core_data_valid <= r_rd_vld;
      r_core_data_in    <= r_rd_vld ? w_ram_dout : '0;
    end
  end

  assign s_ready         = r_s_ready;
  assign busy            = r_busy;
  assign result          = r_result;
  assign result_valid    = r_result_valid;
  assign err_timeout     = r_err_timeout;
  assign core_data_in    = r_core_data_in;
  assign core_data_valid = r_core_data_valid;

endmodule

// File: tb/tb_cnn_image_feeder.sv
// Directed bench for cnn_image_feeder: load/stream/wait flow, upstream gaps,
// core answer, timeout, answer/timeout collision and reset mid-load.
module tb_cnn_image_feeder;
  import cnn_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] core_data_in;
  logic              core_data_valid;
  logic [CLS_W-1:0]  core_decision = '0;
  logic              core_out_valid = 1'b0;
  logic [CLS_W-1:0]  result;
  logic              result_valid;
  logic              err_timeout;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;

  cnn_image_feeder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_data          (s_data),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .core_data_in    (core_data_in),
    .core_data_valid (core_data_valid),
    .core_decision   (core_decision),
    .core_out_valid  (core_out_valid),
    .result          (result),
    .result_valid    (result_valid),
    .err_timeout     (err_timeout),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int mode, input int i);
    if (mode == 0) return 8'(i);
    return 8'hA5;
  endfunction

  // Feed one image; optional 1-of-3 gaps and an out_valid pulse during LOAD.
  task automatic load_image(input int mode, input bit gap, input int inj);
    int acc = 0;
    int cyc = 0;
    int rv_bad = 0;
    bit was;
    while (acc < int'(N_PIX) && cyc < 5000) begin
      s_valid        = gap ? (cyc % 3 == 0) : 1'b1;
      s_data         = pix(mode, acc);
      core_out_valid = (cyc == inj);
      core_decision  = 4'd3;
      was            = s_valid && s_ready;
      tick();
      if (was) acc++;
      cyc++;
      if (result_valid) rv_bad++;
    end
    s_valid        = 1'b0;
    core_out_valid = 1'b0;
    chk("load_count", acc, N_PIX);
    chk("load_no_result_valid", rv_bad, 0);
    chk("sready_drop", s_ready, 1'b0);
    chk("busy_stream", busy, 1'b1);
  endtask

  // Check the 784-cycle burst starting 2 cycles after the last accepted beat.
  task automatic stream_check(input int mode);
    int bad = 0;
    int srb = 0;
    tick();
    chk("lat_early", core_data_valid, 1'b0);
    for (int k = 0; k < int'(N_PIX); k++) begin
      tick();
      if (!core_data_valid || core_data_in !== pix(mode, k)) bad++;
      if (s_ready || !busy) srb++;
    end
    chk("stream_data", bad, 0);
    chk("sready_busy_stream", srb, 0);
    tick();
    chk("valid_tail", core_data_valid, 1'b0);
    chk("data_tail", core_data_in, 8'h00);
  endtask

  initial begin
    int n;
    int rvb;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sready", s_ready, 1'b0);
    chk("rst_valid", core_data_valid, 1'b0);
    chk("rst_data", core_data_in, 8'h00);
    chk("rst_result", result, 4'd0);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("sready_after_rst", s_ready, 1'b1);

    // Ramp image, continuous valid, core answers 7 after 300 cycles
    load_image(0, 1'b0, -1);
    stream_check(0);
    rvb = 0;
    repeat (300) begin
      tick();
      if (result_valid || err_timeout || s_ready) rvb++;
    end
    chk("wait_quiet", rvb, 0);
    core_out_valid = 1'b1;
    core_decision  = 4'd7;
    tick();
    core_out_valid = 1'b0;
    chk("ans_rv", result_valid, 1'b1);
    chk("ans_result", result, 4'd7);
    chk("ans_sready", s_ready, 1'b1);
    chk("ans_busy", busy, 1'b0);
    chk("ans_err", err_timeout, 1'b0);
    tick();
    chk("ans_rv_pulse", result_valid, 1'b0);
    chk("ans_result_hold", result, 4'd7);

    // Gapped upstream with an out_valid during LOAD, then core never answers
    load_image(0, 1'b1, 50);
    chk("load_ignore_result", result, 4'd7);
    stream_check(0);
    n = 0;
    rvb = 0;
    while (!err_timeout && n < 9000) begin
      tick();
      n++;
      if (result_valid) rvb++;
    end
    // WAIT began two edges before stream_check returned
    chk("tmo_cycles", n, TIMEOUT_CYC - 2);
    chk("tmo_result_hold", result, 4'd7);
    chk("tmo_no_rv", rvb, 0);
    chk("tmo_sready", s_ready, 1'b1);
    tick();
    chk("tmo_pulse", err_timeout, 1'b0);

    // Answer arrives on the exact timeout cycle
    load_image(0, 1'b0, -1);
    stream_check(0);
    rvb = 0;
    repeat (TIMEOUT_CYC - 3) begin
      tick();
      if (err_timeout || result_valid) rvb++;
    end
    chk("edge_quiet", rvb, 0);
    core_out_valid = 1'b1;
    core_decision  = 4'd9;
    tick();
    core_out_valid = 1'b0;
    chk("edge_rv", result_valid, 1'b1);
    chk("edge_result", result, 4'd9);
    chk("edge_no_err", err_timeout, 1'b0);
    tick();
    chk("edge_no_err_late", err_timeout, 1'b0);

    // Reset after 400 bytes, then a full A5 image
    s_valid = 1'b1;
    s_data  = 8'h3C;
    repeat (400) tick();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    tick();
    chk("midrst_sready", s_ready, 1'b0);
    chk("midrst_result", result, 4'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_sready_up", s_ready, 1'b1);
    load_image(1, 1'b0, -1);
    stream_check(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
